fetch_unit: RTL and testbench

- Instruction-fetch front end for the single-cycle LEGv8 datapath.
- Produces the 32-bit instruction stream and its opcode field Op = instr[31:21], which feed maindec and the rest of decode.
- Holds the PC and issues requests to a synchronous-read instruction memory.
- Buffers returned words in a small FIFO, delivers them over a valid/ready handshake, and accepts branch redirects from execute.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch front end: PC, synchronous imem requests, prefetch FIFO and redirect.
// Define ILLEGAL_OP_EN to classify opcodes and stop fetching after an unsupported one.
module fetch_unit #(
    parameter int             N        = 64,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    output logic [10:0]  instr_op,
    output logic         instr_illegal,
    output logic         halted
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [N-1:0]     pc_r;
    logic [N-1:0]     req_pc_r;
    logic             inflight_r;
    logic             halted_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic [31:0]      mem_instr_r [DEPTH];
    logic [N-1:0]     mem_pc_r    [DEPTH];
    logic [DEPTH-1:0] mem_ill_r;

    logic             req_s;
    logic             push_s;
    logic             pop_s;
    logic             push_ill_s;
    logic [AW+1:0]    occ_s;

`ifdef ILLEGAL_OP_EN
    function automatic logic op_supported(input logic [10:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            11'b11111000010: ok = 1'b1;  // LDUR
            11'b11111000000: ok = 1'b1;  // STUR
            11'b10001011000: ok = 1'b1;  // ADD
            11'b11001011000: ok = 1'b1;  // SUB
            11'b10001010000: ok = 1'b1;  // AND
            11'b10101010000: ok = 1'b1;  // ORR
            default:         ok = (op[10:3] == 8'b10110100);  // CBZ
        endcase
        return ok;
    endfunction

    assign push_ill_s = ~op_supported(imem_rdata[31:21]);
`else
    assign push_ill_s = 1'b0;
`endif

    // Per-cycle request, push and pop decisions; reset and redirect suppress all three.
    always_comb begin
        occ_s  = {1'b0, count_r} + {{(AW+1){1'b0}}, inflight_r};
        req_s  = 1'b0;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (reset || redirect) begin
            req_s  = 1'b0;
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            // The in-flight slot is counted so a full FIFO can never overflow.
            req_s  = !halted_r && (occ_s < DEPTH_C);
            push_s = inflight_r && !halted_r;
            pop_s  = (count_r != (AW+1)'(0)) && instr_ready;
        end
    end

    assign imem_req      = req_s;
    assign imem_addr     = pc_r;
    assign instr_valid   = (count_r != (AW+1)'(0)) && !reset;
    assign instr         = mem_instr_r[rd_ptr_r];
    assign instr_pc      = mem_pc_r[rd_ptr_r];
    assign instr_op      = instr[31:21];
    assign instr_illegal = instr_valid && mem_ill_r[rd_ptr_r];
    assign halted        = halted_r && !reset;

    // Control state: PC, in-flight tracking, FIFO pointers and halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
            rd_ptr_r   <= AW'(0);
            wr_ptr_r   <= AW'(0);
            count_r    <= (AW+1)'(0);
        end else if (redirect) begin
            // Clearing inflight drops any response still owed to the old stream.
            pc_r       <= {redirect_pc[N-1:2], 2'b00};
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
            rd_ptr_r   <= AW'(0);
            wr_ptr_r   <= AW'(0);
            count_r    <= (AW+1)'(0);
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                pc_r     <= pc_r + N'(4);
                req_pc_r <= pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && push_ill_s) begin
                halted_r <= 1'b1;
            end
        end
    end

    // FIFO storage; slots outside the live window are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_instr_r[wr_ptr_r] <= imem_rdata;
            mem_pc_r[wr_ptr_r]    <= req_pc_r;
            mem_ill_r[wr_ptr_r]   <= push_ill_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_fetch_unit;
    localparam int N     = 64;
    localparam int DEPTH = 4;
`ifdef ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [N-1:0]  redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [N-1:0]  instr_pc;
    logic [10:0]   instr_op;
    logic          instr_illegal;
    logic          halted;

    always #5 clk = ~clk;

    fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_op(instr_op), .instr_illegal(instr_illegal),
        .halted(halted)
    );

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
        bit          ill;
    } ent_t;

    int          mode;
    int          n_checks;
    int          n_fail;
    ent_t        q[$];
    logic [63:0] m_pc;
    logic [63:0] m_pend_pc;
    bit          m_pend;
    bit          m_halt;

    bit          s_req, s_valid, s_ill, s_halt;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_instr;
    logic [10:0] s_op;

    function automatic bit legal_op(input logic [10:0] op);
        return (op == 11'b11111000010) || (op == 11'b11111000000) ||
               (op[10:3] == 8'b10110100) || (op == 11'b10001011000) ||
               (op == 11'b11001011000) || (op == 11'b10001010000) ||
               (op == 11'b10101010000);
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        logic [10:0] op;
        case (mode)
            0: return 32'h8B00_0000 | {11'd0, a[20:0]};
            1: return (a == 64'd8) ? 32'h0000_0001 : 32'h8B00_0000;
            2: return (a == 64'd0) ? 32'hF840_03E0 : (32'h8B00_0000 | {11'd0, a[20:0]});
            default: begin
                h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
                case (h[30:28])
                    3'd0:    op = 11'b11111000010;
                    3'd1:    op = 11'b11111000000;
                    3'd2:    op = {8'b10110100, h[2:0]};
                    3'd3:    op = 11'b10001011000;
                    3'd4:    op = 11'b11001011000;
                    3'd5:    op = 11'b10001010000;
                    3'd6:    op = 11'b10101010000;
                    default: op = h[26:16];
                endcase
                return {op, h[20:0]};
            end
        endcase
    endfunction

    // Synchronous instruction memory: data appears the cycle after a request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        bit   e_valid, e_req;
        ent_t h;
        e_valid = !reset && (q.size() > 0);
        e_req   = !reset && !redirect && !m_halt && ((q.size() + int'(m_pend)) < DEPTH);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, e_valid);
        chk("halted", halted, !reset && m_halt);
        if (e_valid) begin
            h = q[0];
            chk("instr_pc", instr_pc, h.pc);
            chk("instr", instr, h.w);
            chk("instr_op", instr_op, h.w[31:21]);
            chk("instr_illegal", instr_illegal, h.ill);
        end else begin
            chk("instr_illegal_idle", instr_illegal, 1'b0);
        end
    endtask

    task automatic model_update(input bit rst, input bit rd, input logic [63:0] rpc, input bit rdy);
        bit   req;
        ent_t e;
        req = !rst && !rd && !m_halt && ((q.size() + int'(m_pend)) < DEPTH);
        if (rst) begin
            m_pc = 64'd0; q.delete(); m_pend = 1'b0; m_halt = 1'b0;
        end else if (rd) begin
            q.delete(); m_pc = {rpc[63:2], 2'b00}; m_pend = 1'b0; m_halt = 1'b0;
        end else begin
            if ((q.size() > 0) && rdy) void'(q.pop_front());
            if (m_pend && !m_halt) begin
                e.w   = mem_word(m_pend_pc);
                e.pc  = m_pend_pc;
                e.ill = ILL_EN && !legal_op(e.w[31:21]);
                q.push_back(e);
                if (e.ill) m_halt = 1'b1;
            end
            m_pend = req;
            if (req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 64'd4;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit rd, input logic [63:0] rpc, input bit rdy);
        reset = rst; redirect = rd; redirect_pc = rpc; instr_ready = rdy;
        #1;
        compare();
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc;
        s_instr = instr; s_op = instr_op; s_ill = instr_illegal; s_halt = halted;
        @(posedge clk);
        model_update(rst, rd, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset(input int m);
        mode = m;
        cycle(1'b1, 1'b0, 64'd0, 1'b1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
            if (s_valid) ok = 1'b1;
        end
        if (!ok) chk(name, 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] max_addr;
        int          nreq;
        bit          seen8, ill8;

        n_checks = 0; n_fail = 0; mode = 0;
        q.delete(); m_pc = 64'd0; m_pend_pc = 64'd0; m_pend = 1'b0; m_halt = 1'b0;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; instr_ready = 1'b0;
        @(negedge clk);

        // Reset release with ready high: addresses 0,4,8,12, delivery from the 3rd cycle.
        do_reset(0);
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_req", s_req, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
            if (i < 4) begin
                chk("s1_req", s_req, 1'b1);
                chk("s1_addr", s_addr, 64'(4 * i));
            end
            chk("s1_valid", s_valid, (i >= 2));
            if (i >= 2) chk("s1_pc", s_pc, 64'(4 * (i - 2)));
        end

        // Consumer stalled 10 cycles: exactly DEPTH requests, head pinned at PC 0.
        do_reset(0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b0);
            if (s_req) nreq++;
        end
        chk("s2_nreq", 64'(nreq), 64'd4);
        chk("s2_head_pc", s_pc, 64'd0);
        exp_pc = 64'd0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
            chk("s2_stream_valid", s_valid, 1'b1);
            chk("s2_stream_pc", s_pc, exp_pc);
            exp_pc = exp_pc + 64'd4;
        end

        // Redirect with three queued entries and one request in flight.
        do_reset(0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0);
        cycle(1'b0, 1'b1, 64'h103, 1'b0);
        chk("s3_pre_valid", s_valid, 1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("s3_flushed", s_valid, 1'b0);
        chk("s3_req", s_req, 1'b1);
        chk("s3_addr", s_addr, 64'h100);
        wait_valid("s3_timeout", 10);
        chk("s3_pc", s_pc, 64'h100);

        // LDUR word at PC 0.
        do_reset(2);
        wait_valid("s4_timeout", 10);
        chk("s4_instr", s_instr, 32'hF840_03E0);
        chk("s4_op", s_op, 11'b11111000010);

        // Illegal word at PC 8.
        do_reset(1);
        max_addr = 64'd0; seen8 = 1'b0; ill8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
            if (s_req && s_addr > max_addr) max_addr = s_addr;
            if (s_valid && s_pc == 64'd8) begin seen8 = 1'b1; ill8 = s_ill; end
            if (s_valid && s_pc < 64'd8) chk("s5_legal_ill", s_ill, 1'b0);
        end
        chk("s5_seen8", seen8, 1'b1);
        chk("s5_ill8", ill8, ILL_EN);
        chk("s5_halted", s_halt, ILL_EN);
        chk("s5_stop_at_12", (max_addr == 64'd12), ILL_EN);
        cycle(1'b0, 1'b1, 64'd0, 1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("s5_unhalt", s_halt, 1'b0);
        chk("s5_resume_req", s_req, 1'b1);
        chk("s5_resume_addr", s_addr, 64'd0);

        // PC wrap through the top of the address space, then reset mid-stream.
        do_reset(0);
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
            chk("s6_req", s_req, 1'b1);
            chk("s6_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i));
        end
        chk("s6_valid_before", s_valid, 1'b1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1);
        chk("s6_rst_valid", s_valid, 1'b0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("s6_restart_valid", s_valid, 1'b0);
        chk("s6_restart_addr", s_addr, 64'd0);

        // Randomized traffic: stalls, redirects, occasional reset, mixed opcodes.
        do_reset(3);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 29) == 0),
                  {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
